reg_bank_wb: RTL and testbench

//  Register bank at the consuming end of the write-back path: accepts the word selected by the

---
 rtl/reg_bank_pkg.sv | 25 ++
 rtl/reg_scoreboard.sv | 75 +++++++
 rtl/reg_bank_wb.sv | 120 ++++++++++++
 tb/tb_reg_bank_wb.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/reg_bank_pkg.sv
// ---------------------------------------------------------------------------
// reg_bank_pkg
// Shared types and constants for the write-back register bank:
//   reg_idx_t     5-bit register index
//   REG_ZERO      hard-wired zero register
//   REG_SP        stack-pointer register index
//   SP_RESET_VAL  stack-pointer value after reset
//   DATA_W        register / data-port width
// ---------------------------------------------------------------------------
package reg_bank_pkg;

  localparam int DATA_W       = 32;
  localparam int SP_RESET_VAL = 227;

  typedef logic [4:0] reg_idx_t;

  localparam reg_idx_t REG_ZERO = 5'd0;
  localparam reg_idx_t REG_SP   = 5'd29;

  // True for any index other than the hard-wired zero register
  function automatic logic idx_live(input reg_idx_t idx);
    return idx != REG_ZERO;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// ---------------------------------------------------------------------------
// reg_scoreboard
// Pending-result tracker for the register bank. A claim marks a register as
// still owed a long-latency result; a write-back clears it. A claim beats a
// same-cycle write to the same register (the newer producer wins).
// Ports:
//   clk, reset_n          clock, async active-low reset
//   wr_en_i, wr_addr_i    write-back commit (clears pending)
//   claim_en_i, claim_addr_i  long-latency issue (sets pending)
//   rd_addr_a_i/b_i       read-port indices for busy lookup
//   busy_a_o/b_o          combinational: addressed register is pending
//   claim_err_o           registered 1-cycle pulse: claim on a pending register
// ---------------------------------------------------------------------------
module reg_scoreboard
  import reg_bank_pkg::*;
(
  input  logic     clk,
  input  logic     reset_n,
  input  logic     wr_en_i,
  input  logic [4:0] wr_addr_i,
  input  logic     claim_en_i,
  input  logic [4:0] claim_addr_i,
  input  logic [4:0] rd_addr_a_i,
  input  logic [4:0] rd_addr_b_i,
  output logic     busy_a_o,
  output logic     busy_b_o,
  output logic     claim_err_o
);

  logic [31:0] pending_q;
  logic [31:0] pending_d;
  logic        claim_err_q;
  logic        claim_err_d;
  logic        wr_live_s;
  logic        claim_live_s;

  assign wr_live_s    = wr_en_i && idx_live(wr_addr_i);
  assign claim_live_s = claim_en_i && idx_live(claim_addr_i);

  // Next pending vector: clear on write first, then claim overrides
  always_comb begin
    pending_d   = pending_q;
    claim_err_d = 1'b0;
    if (wr_live_s) begin
      pending_d[wr_addr_i] = 1'b0;
    end else begin
      pending_d = pending_d;
    end
    if (claim_live_s) begin
      pending_d[claim_addr_i] = 1'b1;
      // A same-cycle write to the same register retires the old producer,
      // so re-claiming it is legitimate.
      claim_err_d = pending_q[claim_addr_i] &&
                    !(wr_live_s && (wr_addr_i == claim_addr_i));
    end else begin
      claim_err_d = 1'b0;
    end
  end

  // Pending vector and error pulse registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_q   <= 32'd0;
      claim_err_q <= 1'b0;
    end else begin
      pending_q   <= pending_d;
      claim_err_q <= claim_err_d;
    end
  end

  assign busy_a_o    = idx_live(rd_addr_a_i) && pending_q[rd_addr_a_i];
  assign busy_b_o    = idx_live(rd_addr_b_i) && pending_q[rd_addr_b_i];
  assign claim_err_o = claim_err_q;

endmodule

// File: rtl/reg_bank_wb.sv
// ---------------------------------------------------------------------------
// reg_bank_wb
// Register bank at the end of the write-back path. 32 x DATA_W storage,
// register 0 hard-wired to zero, two registered read ports and a pending
// scoreboard (reg_scoreboard) for long-latency producers.
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   wr_en, wr_addr, wr_data      write-back commit
//   claim_en, claim_addr         mark register pending
//   rd_addr_a/b -> rd_data_a/b   registered reads, 1-cycle latency
//   busy_a/b                     combinational pending flag for read addresses
//   claim_err                    1-cycle pulse: claim hit a pending register
// Build option: define WB_BYPASS_EN to forward same-edge write data to the
// read ports; otherwise reads return the pre-write contents.
// ---------------------------------------------------------------------------
module reg_bank_wb
  import reg_bank_pkg::*;
#(
  parameter int DATA_W   = reg_bank_pkg::DATA_W,
  parameter int SP_IDX   = int'(REG_SP),
  parameter int SP_RESET = SP_RESET_VAL
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [4:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              claim_en,
  input  logic [4:0]        claim_addr,
  input  logic [4:0]        rd_addr_a,
  input  logic [4:0]        rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              busy_a,
  output logic              busy_b,
  output logic              claim_err
);

  logic [DATA_W-1:0] regs_q [32];
  logic [DATA_W-1:0] rd_data_a_q;
  logic [DATA_W-1:0] rd_data_b_q;
  logic [DATA_W-1:0] rd_data_a_d;
  logic [DATA_W-1:0] rd_data_b_d;
  logic              wr_live_s;

  assign wr_live_s = wr_en && idx_live(wr_addr);

  // Read-port next values; zero register always reads 0
  always_comb begin
    rd_data_a_d = {DATA_W{1'b0}};
    rd_data_b_d = {DATA_W{1'b0}};
    if (idx_live(rd_addr_a)) begin
      rd_data_a_d = regs_q[rd_addr_a];
    end else begin
      rd_data_a_d = {DATA_W{1'b0}};
    end
    if (idx_live(rd_addr_b)) begin
      rd_data_b_d = regs_q[rd_addr_b];
    end else begin
      rd_data_b_d = {DATA_W{1'b0}};
    end
`ifdef WB_BYPASS_EN
    if (wr_live_s && (wr_addr == rd_addr_a)) begin
      rd_data_a_d = wr_data;
    end else begin
      rd_data_a_d = rd_data_a_d;
    end
    if (wr_live_s && (wr_addr == rd_addr_b)) begin
      rd_data_b_d = wr_data;
    end else begin
      rd_data_b_d = rd_data_b_d;
    end
`else
    rd_data_a_d = rd_data_a_d;
    rd_data_b_d = rd_data_b_d;
`endif
  end

  // Storage array: reset to zero with the stack pointer preloaded
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= (i == SP_IDX) ? DATA_W'(SP_RESET) : {DATA_W{1'b0}};
      end
    end else if (wr_live_s) begin
      regs_q[wr_addr] <= wr_data;
    end else begin
      regs_q[wr_addr] <= regs_q[wr_addr];
    end
  end

  // Registered read ports
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data_a_q <= {DATA_W{1'b0}};
      rd_data_b_q <= {DATA_W{1'b0}};
    end else begin
      rd_data_a_q <= rd_data_a_d;
      rd_data_b_q <= rd_data_b_d;
    end
  end

  assign rd_data_a = rd_data_a_q;
  assign rd_data_b = rd_data_b_q;

  reg_scoreboard u_scoreboard (
    .clk          (clk),
    .reset_n      (reset_n),
    .wr_en_i      (wr_en),
    .wr_addr_i    (wr_addr),
    .claim_en_i   (claim_en),
    .claim_addr_i (claim_addr),
    .rd_addr_a_i  (rd_addr_a),
    .rd_addr_b_i  (rd_addr_b),
    .busy_a_o     (busy_a),
    .busy_b_o     (busy_b),
    .claim_err_o  (claim_err)
  );

endmodule

// File: tb/tb_reg_bank_wb.sv
module tb_reg_bank_wb;

  logic        clk;
  logic        reset_n;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        claim_en;
  logic [4:0]  claim_addr;
  logic [4:0]  rd_addr_a;
  logic [4:0]  rd_addr_b;
  logic [31:0] rd_data_a;
  logic [31:0] rd_data_b;
  logic        busy_a;
  logic        busy_b;
  logic        claim_err;

  int tests_run;
  int tests_failed;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] m_regs [32];
  logic [31:0] m_pend;

  reg_bank_wb dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .claim_en   (claim_en),
    .claim_addr (claim_addr),
    .rd_addr_a  (rd_addr_a),
    .rd_addr_b  (rd_addr_b),
    .rd_data_a  (rd_data_a),
    .rd_data_b  (rd_data_b),
    .busy_a     (busy_a),
    .busy_b     (busy_b),
    .claim_err  (claim_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_regs[29] = 32'd227;
    m_pend = 32'd0;
    exp_q.delete();
  endtask

  // Drive one cycle of stimulus (called just after a posedge), check busy
  // before the edge, then check registered outputs just after it.
  task automatic cycle(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic ce, input logic [4:0] ca,
                       input logic [4:0] ra, input logic [4:0] rb);
    exp_t e;
    wr_en = we; wr_addr = wa; wr_data = wd;
    claim_en = ce; claim_addr = ca;
    rd_addr_a = ra; rd_addr_b = rb;
    #1;
    check_eq("busy_a", {31'd0, busy_a}, {31'd0, (ra != 5'd0) && m_pend[ra]});
    check_eq("busy_b", {31'd0, busy_b}, {31'd0, (rb != 5'd0) && m_pend[rb]});
    e.a = (ra == 5'd0) ? 32'd0 : m_regs[ra];
    e.b = (rb == 5'd0) ? 32'd0 : m_regs[rb];
`ifdef WB_BYPASS_EN
    if (we && wa != 5'd0 && wa == ra) e.a = wd;
    if (we && wa != 5'd0 && wa == rb) e.b = wd;
`endif
    e.err = ce && (ca != 5'd0) && m_pend[ca] && !(we && wa == ca);
    exp_q.push_back(e);
    if (we && wa != 5'd0) begin
      m_regs[wa] = wd;
      m_pend[wa] = 1'b0;
    end
    if (ce && ca != 5'd0) m_pend[ca] = 1'b1;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check_eq("queue_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check_eq("rd_data_a", rd_data_a, e.a);
      check_eq("rd_data_b", rd_data_b, e.b);
      check_eq("claim_err", {31'd0, claim_err}, {31'd0, e.err});
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    reset_n = 1'b0;
    wr_en = 1'b0; wr_addr = 5'd0; wr_data = 32'd0;
    claim_en = 1'b0; claim_addr = 5'd0;
    rd_addr_a = 5'd0; rd_addr_b = 5'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_rd_a", rd_data_a, 32'd0);
    check_eq("rst_rd_b", rd_data_b, 32'd0);
    check_eq("rst_err", {31'd0, claim_err}, 32'd0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: reset contents
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd29, 5'd5);
    // 2: zero register ignores writes; normal write/read
    cycle(1'b1, 5'd0, 32'hDEADBEEF, 1'b0, 5'd0, 5'd1, 5'd2);
    cycle(1'b1, 5'd8, 32'h12345678, 1'b0, 5'd0, 5'd0, 5'd0);
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd8, 5'd8);
    // 3: claim then clear by write-back
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 5'd4, 5'd0);
    cycle(1'b1, 5'd4, 32'h55, 1'b0, 5'd0, 5'd4, 5'd0);
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd4, 5'd4);
    // 4: double claim -> one-cycle error pulse; claim-zero is harmless
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 5'd4, 5'd0);
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 5'd4, 5'd0);
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd4, 5'd0);
    // claim + write same register same cycle: newer producer wins, no error
    cycle(1'b1, 5'd4, 32'h66, 1'b1, 5'd4, 5'd4, 5'd0);
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd4, 5'd4);
    cycle(1'b1, 5'd4, 32'h77, 1'b0, 5'd0, 5'd4, 5'd0);
    // 5: write during read of the same register
    cycle(1'b1, 5'd9, 32'h11111111, 1'b0, 5'd0, 5'd0, 5'd0);
    cycle(1'b1, 5'd9, 32'hA5A5A5A5, 1'b0, 5'd0, 5'd9, 5'd9);
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd9, 5'd29);

    // Mixed traffic over a small address window to force collisions
    for (int n = 0; n < 60; n++) begin
      cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom(),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);

    // 6: async reset mid-cycle discards claims
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 5'd3, 5'd7);
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd3, 5'd7);
    claim_en = 1'b0;
    rd_addr_a = 5'd3; rd_addr_b = 5'd7;
    #1;
    check_eq("pre_rst_busy_a", {31'd0, busy_a}, 32'd1);
    check_eq("pre_rst_busy_b", {31'd0, busy_b}, 32'd1);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_eq("async_busy_a", {31'd0, busy_a}, 32'd0);
    check_eq("async_busy_b", {31'd0, busy_b}, 32'd0);
    check_eq("async_rd_a", rd_data_a, 32'd0);
    check_eq("async_err", {31'd0, claim_err}, 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd29, 5'd8);
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd3, 5'd7);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
